slot_entry_controller: RTL and testbench

SLOT_ENTRY_CONTROLLER -- requirements
Module: slot_entry_controller

---
 rtl/slot_entry_controller_pkg.sv | 21 ++
 rtl/slot_occupancy_bank.sv | 62 ++++++
 rtl/slot_entry_controller.sv | 89 ++++++++
 tb/tb_slot_entry_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/slot_entry_controller_pkg.sv
// Shared definitions for the parking-slot controllers: slot count define,
// response codes and the entry FSM state encoding.
`ifndef PARKING_SLOTS
`define PARKING_SLOTS 8
`endif

package slot_entry_controller_pkg;

  typedef enum logic [1:0] {
    RESP_GRANTED          = 2'b00,
    RESP_ALREADY_OCCUPIED = 2'b01,
    RESP_INVALID_FLAT     = 2'b10
  } resp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_RESP  = 2'b10
  } state_e;

endpackage

// File: rtl/slot_occupancy_bank.sv
// Per-flat occupancy bits with a registered population count and full flag.
// A clear in the same cycle as a read/set is applied first.
module slot_occupancy_bank #(
  parameter int unsigned N = `PARKING_SLOTS,
  localparam int unsigned FW = $clog2(N) + 1,
  localparam int unsigned CW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en,
  input  logic [FW-1:0] set_idx,
  input  logic          clr_en,
  input  logic [FW-1:0] clr_idx,
  input  logic [FW-1:0] rd_idx,
  output logic          rd_bit,
  output logic [N:0]    occupancy,
  output logic [CW-1:0] count,
  output logic          full
);

  logic          clr_hit;
  logic          set_hit;
  logic [N:0]    after_clr;
  logic [N:0]    occ_nxt;
  logic [CW-1:0] count_nxt;

  // Loops compare against each in-range index, so out-of-range flats never match.
  always_comb begin
    clr_hit   = 1'b0;
    set_hit   = 1'b0;
    rd_bit    = 1'b0;
    after_clr = occupancy;
    for (int unsigned i = 0; i <= N; i++) begin
      if (clr_en && clr_idx == FW'(i) && occupancy[i]) begin
        clr_hit      = 1'b1;
        after_clr[i] = 1'b0;
      end
    end
    occ_nxt = after_clr;
    for (int unsigned i = 0; i <= N; i++) begin
      if (rd_idx == FW'(i)) rd_bit = after_clr[i];
      if (set_en && set_idx == FW'(i) && !after_clr[i]) begin
        set_hit    = 1'b1;
        occ_nxt[i] = 1'b1;
      end
    end
    count_nxt = count + CW'(set_hit) - CW'(clr_hit);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
      count     <= '0;
      full      <= 1'b0;
    end else begin
      occupancy <= occ_nxt;
      count     <= count_nxt;
      full      <= (count_nxt == CW'(N + 1));
    end
  end

endmodule

// File: rtl/slot_entry_controller.sv
// Entry-side controller: accepts one entry request at a time, checks the
// occupancy bank and returns a GRANTED / ALREADY_OCCUPIED / INVALID_FLAT outcome.
module slot_entry_controller
  import slot_entry_controller_pkg::*;
#(
  parameter int unsigned N = `PARKING_SLOTS,
  localparam int unsigned FW = $clog2(N) + 1,
  localparam int unsigned CW = $clog2(N + 2)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          entry_valid,
  input  logic [FW-1:0] entry_flat,
  output logic          entry_ready,
  input  logic          exit_valid,
  input  logic [FW-1:0] exit_flat,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [1:0]    resp_code,
  output logic [FW-1:0] resp_flat,
  output logic [N:0]    occupancy,
  output logic [CW-1:0] occupied_count,
  output logic          lot_full
);

  state_e        state, state_nxt;
  logic [FW-1:0] flat_q;
  resp_code_e    code_q, outcome;
  logic          set_en;
  logic          rd_bit;

  slot_occupancy_bank #(.N(N)) u_bank (
    .clk       (clk),
    .rst       (rst),
    .set_en    (set_en),
    .set_idx   (flat_q),
    .clr_en    (exit_valid),
    .clr_idx   (exit_flat),
    .rd_idx    (flat_q),
    .rd_bit    (rd_bit),
    .occupancy (occupancy),
    .count     (occupied_count),
    .full      (lot_full)
  );

  always_comb begin
    state_nxt   = state;
    entry_ready = 1'b0;
    resp_valid  = 1'b0;
    set_en      = 1'b0;
    outcome     = RESP_GRANTED;
    case (state)
      ST_IDLE: begin
        entry_ready = 1'b1;
        if (entry_valid) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        if (flat_q > FW'(N))  outcome = RESP_INVALID_FLAT;
        else if (rd_bit)      outcome = RESP_ALREADY_OCCUPIED;
        else                  set_en  = 1'b1;
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      flat_q    <= '0;
      code_q    <= RESP_GRANTED;
      resp_flat <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && entry_valid) flat_q <= entry_flat;
      if (state == ST_CHECK) begin
        code_q    <= outcome;
        resp_flat <= flat_q;
      end
    end
  end

  assign resp_code = code_q;

endmodule

// File: tb/tb_slot_entry_controller.sv
// Scoreboard bench for slot_entry_controller with an occupancy reference model.
module tb_slot_entry_controller;
  import slot_entry_controller_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned FW = 4;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          entry_valid;
  logic [FW-1:0] entry_flat;
  logic          entry_ready;
  logic          exit_valid;
  logic [FW-1:0] exit_flat;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_code;
  logic [FW-1:0] resp_flat;
  logic [N:0]    occupancy;
  logic [CW-1:0] occupied_count;
  logic          lot_full;

  slot_entry_controller #(.N(N)) dut (
    .clk            (clk),
    .rst            (rst),
    .entry_valid    (entry_valid),
    .entry_flat     (entry_flat),
    .entry_ready    (entry_ready),
    .exit_valid     (exit_valid),
    .exit_flat      (exit_flat),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_code      (resp_code),
    .resp_flat      (resp_flat),
    .occupancy      (occupancy),
    .occupied_count (occupied_count),
    .lot_full       (lot_full)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [N:0]  m_occ;
  logic [FW+1:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_exit(input logic [FW-1:0] f);
    if (f <= FW'(N) && m_occ[f]) m_occ[f] = 1'b0;
  endfunction

  function automatic resp_code_e model_entry(input logic [FW-1:0] f);
    if (f > FW'(N)) return RESP_INVALID_FLAT;
    if (m_occ[f]) return RESP_ALREADY_OCCUPIED;
    m_occ[f] = 1'b1;
    return RESP_GRANTED;
  endfunction

  task automatic check_bank(input string tag);
    check({tag, "_occ"},   32'(occupancy),      32'(m_occ));
    check({tag, "_count"}, 32'(occupied_count), 32'($countones(m_occ)));
    check({tag, "_full"},  32'(lot_full),       32'(m_occ == '1));
  endtask

  task automatic do_entry(input logic [FW-1:0] flat, input bit with_exit,
                          input logic [FW-1:0] xflat, input int hold);
    int         waited;
    resp_code_e code;
    logic [FW+1:0] exp;
    waited = 0;
    while (entry_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (entry_ready !== 1'b1) begin
      check("ready_timeout", 32'(entry_ready), 32'd1);
      return;
    end
    entry_valid = 1'b1;
    entry_flat  = flat;
    @(posedge clk); #1;
    entry_valid = 1'b0;
    check("check_not_ready", 32'(entry_ready), 32'd0);
    check("check_no_resp",   32'(resp_valid),  32'd0);
    if (with_exit) begin
      exit_valid = 1'b1;
      exit_flat  = xflat;
      model_exit(xflat);
    end
    code = model_entry(flat);
    sb.push_back({code, flat});
    @(posedge clk); #1;
    exit_valid = 1'b0;
    check("resp_latency", 32'(resp_valid), 32'd1);
    for (int i = 0; i < hold; i++) begin
      exp = sb[0];
      check("hold_valid", 32'(resp_valid),  32'd1);
      check("hold_code",  32'(resp_code),   32'(exp[FW+1:FW]));
      check("hold_flat",  32'(resp_flat),   32'(exp[FW-1:0]));
      check("hold_ready", 32'(entry_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    if (resp_valid === 1'b1) begin
      exp = sb.pop_front();
      check("resp_code", 32'(resp_code), 32'(exp[FW+1:FW]));
      check("resp_flat", 32'(resp_flat), 32'(exp[FW-1:0]));
    end else begin
      check("resp_missing", 32'(resp_valid), 32'd1);
    end
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("back_to_idle", 32'(entry_ready), 32'd1);
    check_bank("entry");
  endtask

  task automatic do_exit(input logic [FW-1:0] flat);
    exit_valid = 1'b1;
    exit_flat  = flat;
    model_exit(flat);
    @(posedge clk); #1;
    exit_valid = 1'b0;
    check_bank("exit");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; entry_valid = 1'b0; entry_flat = '0; exit_valid = 1'b0;
    exit_flat = '0; resp_ready = 1'b0; m_occ = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_code",  32'(resp_code),  32'd0);
    check("rst_resp_flat",  32'(resp_flat),  32'd0);
    check_bank("rst");
    rst = 1'b0;
    check("ready_after_rst", 32'(entry_ready), 32'd1);

    do_entry(4'd3, 1'b0, '0, 0);
    do_entry(4'd3, 1'b0, '0, 0);
    do_entry(4'd12, 1'b0, '0, 0);
    for (int f = 0; f <= 8; f++) do_entry(FW'(f), 1'b0, '0, 0);
    do_entry(4'd0, 1'b0, '0, 0);

    do_exit(4'd5);
    do_exit(4'd5);
    do_exit(4'd12);

    // exit and CHECK on the same flat, then on different flats with a stalled consumer
    do_entry(4'd4, 1'b1, 4'd4, 0);
    do_entry(4'd5, 1'b1, 4'd6, 5);

    // reset while the entry for flat 2 is in CHECK
    do_exit(4'd2);
    entry_valid = 1'b1;
    entry_flat  = 4'd2;
    @(posedge clk); #1;
    entry_valid = 1'b0;
    rst = 1'b1;
    #1;
    m_occ = '0;
    check("midrst_resp_valid", 32'(resp_valid),  32'd0);
    check("midrst_idle",       32'(entry_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    check("postrst_ready", 32'(entry_ready), 32'd1);
    @(posedge clk); #1;
    check("postrst_bit2", 32'(occupancy[2]), 32'd0);
    check_bank("postrst");

    do_entry(4'd8, 1'b0, '0, 0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
